// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline stall/flush controller with held-redirect replay
//
// Purpose: merges the external memory stall, hazard-unit stall/flush requests
// and execute-stage redirects into per-stage stall/flush enables for N_STAGES
// pipeline registers. A redirect that arrives while fetch is frozen is held
// and replayed on release. External-stall cycles are counted (saturating).
//
// Ports:
//   clk              clock, all state on rising edge
//   reset            asynchronous active-low reset
//   ext_stall        memory-not-ready stall request
//   haz_stall        hazard stall request per stage
//   haz_flush        hazard flush request per stage
//   redirect_valid   taken branch/jump resolved in execute
//   redirect_pc      redirect target
//   cnt_clear        synchronous clear of stall_cnt
//   stage_stall      hold enable per pipeline register
//   stage_flush      clear-to-bubble per pipeline register
//   pc_sel_redirect  next PC = pc_redirect this cycle
//   pc_redirect      redirect target to fetch mux
//   redirect_pending a held redirect awaits replay
//   stall_cnt        ext_stall cycle counter, saturating
module pipe_ctrl #(
  parameter int N_STAGES     = 5,
  parameter int XLEN         = 32,
  parameter int FRONT_STAGES = 2,
  parameter int REDIRECT_STG = 2,
  parameter int DRAIN_MODE   = 1,
  parameter int CNT_W        = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ext_stall,
  input  logic [N_STAGES-1:0] haz_stall,
  input  logic [N_STAGES-1:0] haz_flush,
  input  logic                redirect_valid,
  input  logic [XLEN-1:0]     redirect_pc,
  input  logic                cnt_clear,
  output logic [N_STAGES-1:0] stage_stall,
  output logic [N_STAGES-1:0] stage_flush,
  output logic                pc_sel_redirect,
  output logic [XLEN-1:0]     pc_redirect,
  output logic                redirect_pending,
  output logic [CNT_W-1:0]    stall_cnt
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t              state, state_nxt;
  logic [XLEN-1:0]     hold_pc, hold_pc_nxt;
  logic [N_STAGES-1:0] req, stall_raw, flush_base, flush_final;
  logic                fetch_stalled;
  logic                replay;
  logic                sel;
  logic [XLEN-1:0]     sel_pc;

  // Per-stage stall requests; in drain mode ext_stall only freezes the front end.
  always_comb begin
    req = '0;
    for (int k = 0; k < N_STAGES; k++) begin
      req[k] = haz_stall[k] | (ext_stall & ((DRAIN_MODE == 0) | (k < FRONT_STAGES)));
    end
  end

  // A stall propagates upstream: stage k holds if any stage at or after k holds.
  always_comb begin
    stall_raw = '0;
    stall_raw[N_STAGES-1] = req[N_STAGES-1];
    for (int k = N_STAGES - 2; k >= 0; k--) begin
      stall_raw[k] = req[k] | stall_raw[k+1];
    end
  end

  // Bubble at the stall boundary, live-redirect flushes, hazard flushes.
  always_comb begin
    flush_base = haz_flush;
    for (int k = 0; k < N_STAGES - 1; k++) begin
      if (stall_raw[k] && !stall_raw[k+1]) flush_base[k+1] = 1'b1;
    end
    for (int k = 1; k < N_STAGES; k++) begin
      if (redirect_valid && (k <= REDIRECT_STG)) flush_base[k] = 1'b1;
    end
  end

  // Stage 0 can only be flushed by the hazard unit, so this is loop-free.
  assign fetch_stalled = stall_raw[0] & ~flush_base[0];

  // Redirect FSM: next-state, hold register update and PC-select outputs.
  always_comb begin
    state_nxt   = state;
    hold_pc_nxt = hold_pc;
    sel         = 1'b0;
    sel_pc      = '0;
    replay      = 1'b0;
    case (state)
      IDLE: begin
        if (redirect_valid) begin
          if (!fetch_stalled) begin
            sel    = 1'b1;
            sel_pc = redirect_pc;
          end else begin
            state_nxt   = HOLD;
            hold_pc_nxt = redirect_pc;
          end
        end
      end
      HOLD: begin
        if (!fetch_stalled) begin
          // A newer live redirect supersedes the held target.
          replay    = 1'b1;
          sel       = 1'b1;
          sel_pc    = redirect_valid ? redirect_pc : hold_pc;
          state_nxt = IDLE;
        end else if (redirect_valid) begin
          hold_pc_nxt = redirect_pc;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The replay kills the wrong-path instruction fetched while frozen.
  always_comb begin
    flush_final    = flush_base;
    flush_final[1] = flush_base[1] | replay;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      hold_pc <= '0;
    end else begin
      state   <= state_nxt;
      hold_pc <= hold_pc_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (cnt_clear) begin
      stall_cnt <= '0;
    end else if (ext_stall && !(&stall_cnt)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  // Combinational outputs are forced low while reset is asserted.
  assign stage_flush      = reset ? flush_final : '0;
  assign stage_stall      = reset ? (stall_raw & ~flush_final) : '0;
  assign pc_sel_redirect  = reset & sel;
  assign pc_redirect      = reset ? sel_pc : '0;
  assign redirect_pending = (state == HOLD);

endmodule
